// File: rtl/cc_sendtimer.sv
// cc_sendtimer: programmable send-strobe generator.
// Captures a data word and a delay D on a start request, waits D+1 cycles in
// COUNT, then raises a one-cycle send strobe while presenting the word.
// Optional feature macro: CC_SENDTIMER_RETRIGGER_EN. When it is defined,
// Start in COUNT recaptures data/delay and restarts the count.
//
// state | meaning
// IDLE  | waiting for Start; data output holds the last captured word
// COUNT | counting the captured delay down to zero
// SEND  | send strobe high for exactly this cycle
module cc_sendtimer #(
  parameter int DATAWIDTH_BUS  = 8,
  parameter int DELAYWIDTH_BUS = 8
) (
  input  logic                      CC_SENDTIMER_CLOCK_50,
  input  logic                      CC_SENDTIMER_RESET_InHigh,
  input  logic [DATAWIDTH_BUS-1:0]  CC_SENDTIMER_Data_inBus,
  input  logic [DELAYWIDTH_BUS-1:0] CC_SENDTIMER_Delay_inBus,
  input  logic                      CC_SENDTIMER_Start_In,
  output logic [DATAWIDTH_BUS-1:0]  CC_SENDTIMER_Data_outBus,
  output logic                      CC_SENDTIMER_SendDataSignal_Out,
  output logic                      CC_SENDTIMER_Busy_Out
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_SEND  = 2'd2
  } state_t;

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [DELAYWIDTH_BUS-1:0] r_count;
  logic [DATAWIDTH_BUS-1:0]  r_data;
  logic                      w_load;
  logic                      w_dec;
  logic                      w_retrig;
  logic                      w_send;
  logic                      w_busy;

`ifdef CC_SENDTIMER_RETRIGGER_EN
  assign w_retrig = CC_SENDTIMER_Start_In;
`else
  assign w_retrig = 1'b0;
`endif

  // State register
  always_ff @(posedge CC_SENDTIMER_CLOCK_50 or posedge CC_SENDTIMER_RESET_InHigh) begin
    if (CC_SENDTIMER_RESET_InHigh) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode plus load/decrement requests for the datapath
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_dec       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (CC_SENDTIMER_Start_In) begin
          w_load      = 1'b1;
          w_state_nxt = ST_COUNT;
        end
      end
      ST_COUNT: begin
        // A retrigger wins even on the terminal count, so the new D always applies.
        if (w_retrig) begin
          w_load = 1'b1;
        end else if (r_count == '0) begin
          w_state_nxt = ST_SEND;
        end else begin
          w_dec = 1'b1;
        end
      end
      ST_SEND: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Data capture register and delay down-counter
  always_ff @(posedge CC_SENDTIMER_CLOCK_50 or posedge CC_SENDTIMER_RESET_InHigh) begin
    if (CC_SENDTIMER_RESET_InHigh) begin
      r_count <= '0;
      r_data  <= '0;
    end else if (w_load) begin
      r_count <= CC_SENDTIMER_Delay_inBus;
      r_data  <= CC_SENDTIMER_Data_inBus;
    end else if (w_dec) begin
      r_count <= r_count - 1'b1;
    end
  end

  // Outputs decode from state only; no input-to-output path
  always_comb begin
    w_send = (r_state == ST_SEND);
    w_busy = (r_state != ST_IDLE);
  end

  assign CC_SENDTIMER_Data_outBus        = r_data;
  assign CC_SENDTIMER_SendDataSignal_Out = w_send;
  assign CC_SENDTIMER_Busy_Out           = w_busy;

endmodule
